pe_window_feeder: RTL and testbench

Read-side window feeder for the convolution array. Sits between the per-column async FIFOs (read ports in the `rd_clk` domain) and the PE columns. Pops one kernel window of `kernel_size` words from all `NUM_CH` column FIFOs in lockstep into a local register window. Then issues that window to the PEs over a valid/ready handshake, replaying it `reuse_cnt+1` times so several filters can share one input window.

---
 rtl/pe_window_feeder_pkg.sv | 18 +
 rtl/pe_window_feeder_regfile.sv | 36 +++
 rtl/pe_window_feeder.sv | 123 ++++++++++++
 tb/tb_pe_window_feeder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_window_feeder_pkg.sv
// Shared types and helpers for the convolution-array window feeder.
package pe_feed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_ISSUE,
    ST_DONE
  } feed_state_t;

  localparam int unsigned CFG_K_W = 8;

  // LSB position of channel ch in a packed multi-channel bus.
  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/pe_window_feeder_regfile.sv
// Window storage: NUM_CH x MAX_K words, one shared-index write port and one
// shared-index combinational read port. Storage is deliberately not reset.
module window_regfile
  import pe_feed_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_K      = 8,
  parameter int unsigned IDX_W      = 3
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [IDX_W-1:0]             widx,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]             ridx,
  output logic [NUM_CH*DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [NUM_CH][MAX_K];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_mem[c][widx] <= wdata[ch_lsb(c, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      rdata[ch_lsb(c, DATA_WIDTH) +: DATA_WIDTH] = r_mem[c][ridx];
    end
  end

endmodule

// File: rtl/pe_window_feeder.sv
// Read-side window feeder: pops one kernel window from all column FIFOs in
// lockstep, then replays it to the PE array reuse_cnt+1 times.
module pe_window_feeder
  import pe_feed_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_K      = 8
) (
  input  logic                         rd_clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [CFG_K_W-1:0]           kernel_size,
  input  logic [CFG_K_W-1:0]           reuse_cnt,
  input  logic [NUM_CH-1:0]            fifo_empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_rdata,
  output logic [NUM_CH-1:0]            fifo_rd_en,
  output logic                         pe_valid,
  input  logic                         pe_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] pe_data,
  output logic                         pe_last,
  output logic                         busy,
  output logic                         done,
  output logic                         err_cfg
);

  localparam int unsigned        IDX_W     = (MAX_K > 1) ? $clog2(MAX_K) : 1;
  localparam logic [CFG_K_W-1:0] MAX_K_CFG = CFG_K_W'(MAX_K);

  feed_state_t           r_state;
  logic [IDX_W-1:0]      r_k_m1;
  logic [CFG_K_W-1:0]    r_reuse;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      r_beat;
  logic [CFG_K_W-1:0]    r_pass;
  logic                  r_err;

  logic                         w_pop;
  logic [NUM_CH*DATA_WIDTH-1:0] w_rdata;

  // Lockstep pop: nothing moves unless every channel has a head word.
  assign w_pop      = (r_state == ST_FILL) && !(|fifo_empty);
  assign fifo_rd_en = {NUM_CH{w_pop}};

  window_regfile #(
    .NUM_CH     (NUM_CH),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_K      (MAX_K),
    .IDX_W      (IDX_W)
  ) u_window (
    .clk   (rd_clk),
    .we    (w_pop),
    .widx  (r_idx),
    .wdata (fifo_rdata),
    .ridx  (r_beat),
    .rdata (w_rdata)
  );

  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_k_m1  <= '0;
      r_reuse <= '0;
      r_idx   <= '0;
      r_beat  <= '0;
      r_pass  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if ((kernel_size == '0) || (kernel_size > MAX_K_CFG)) begin
              r_err <= 1'b1;
            end else begin
              r_k_m1  <= IDX_W'(kernel_size - 8'd1);
              r_reuse <= reuse_cnt;
              r_err   <= 1'b0;
              r_idx   <= '0;
              r_state <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (w_pop) begin
            if (r_idx == r_k_m1) begin
              r_idx   <= '0;
              r_beat  <= '0;
              r_pass  <= '0;
              r_state <= ST_ISSUE;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        ST_ISSUE: begin
          // pe_valid is constant-high here, so pe_ready alone is the handshake.
          if (pe_ready) begin
            if (r_beat == r_k_m1) begin
              r_beat <= '0;
              if (r_pass == r_reuse) begin
                r_state <= ST_DONE;
              end else begin
                r_pass <= r_pass + 8'd1;
              end
            end else begin
              r_beat <= r_beat + IDX_W'(1);
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pe_valid = (r_state == ST_ISSUE);
  assign pe_data  = pe_valid ? w_rdata : '0;
  assign pe_last  = pe_valid && (r_beat == r_k_m1) && (r_pass == r_reuse);
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign err_cfg  = r_err;

endmodule

// File: tb/tb_pe_window_feeder.sv
// Directed bench for pe_window_feeder: FWFT FIFO models, table of window runs,
// plus hand-written reuse-limit and mid-ISSUE reset sequences.
module tb_pe_window_feeder;

  localparam int NUM_CH = 4;
  localparam int DW     = 16;
  localparam int MAX_K  = 8;

  logic                 rd_clk = 1'b0;
  logic                 rstn   = 1'b0;
  logic                 start  = 1'b0;
  logic [7:0]           kernel_size = '0;
  logic [7:0]           reuse_cnt   = '0;
  logic [NUM_CH-1:0]    fifo_empty;
  logic [NUM_CH*DW-1:0] fifo_rdata;
  logic [NUM_CH-1:0]    fifo_rd_en;
  logic                 pe_valid;
  logic                 pe_ready = 1'b1;
  logic [NUM_CH*DW-1:0] pe_data;
  logic                 pe_last;
  logic                 busy;
  logic                 done;
  logic                 err_cfg;

  pe_window_feeder #(
    .NUM_CH     (NUM_CH),
    .DATA_WIDTH (DW),
    .MAX_K      (MAX_K)
  ) dut (
    .rd_clk      (rd_clk),
    .rstn        (rstn),
    .start       (start),
    .kernel_size (kernel_size),
    .reuse_cnt   (reuse_cnt),
    .fifo_empty  (fifo_empty),
    .fifo_rdata  (fifo_rdata),
    .fifo_rd_en  (fifo_rd_en),
    .pe_valid    (pe_valid),
    .pe_ready    (pe_ready),
    .pe_data     (pe_data),
    .pe_last     (pe_last),
    .busy        (busy),
    .done        (done),
    .err_cfg     (err_cfg)
  );

  always #5 rd_clk = ~rd_clk;

  // FWFT FIFO models: wr owned by the stimulus, hd advanced by DUT pops.
  logic [DW-1:0]     fq [NUM_CH][512];
  int                wr [NUM_CH];
  int                hd [NUM_CH];
  logic [NUM_CH-1:0] stall = '0;
  int                cyc = 0;

  always @(posedge rd_clk) begin
    cyc <= cyc + 1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (fifo_rd_en[c]) hd[c] <= hd[c] + 1;
    end
  end

  always_comb begin
    fifo_empty = '0;
    fifo_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      fifo_empty[c]          = (wr[c] == hd[c]) || stall[c];
      fifo_rdata[c*DW +: DW] = fq[c][hd[c] & 511];
    end
  end

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic preload(input int n, input int base);
    for (int c = 0; c < NUM_CH; c++) begin
      for (int j = 0; j < n; j++) begin
        fq[c][wr[c] & 511] = DW'(base + c*16 + j);
        wr[c] = wr[c] + 1;
      end
    end
  endtask

  task automatic flush();
    for (int c = 0; c < NUM_CH; c++) wr[c] = hd[c];
  endtask

  typedef struct {
    int          k;
    int          reuse;
    logic [15:0] rpat;     // pe_ready per valid cycle, LSB first; 1 afterwards
    logic        stall2;   // hold channel 2 empty for the first 5 FILL cycles
    logic        exp_err;
  } vec_t;

  task automatic run_case(input vec_t v, input int id);
    int   base, total, t0, nb, vc, fillc, bad_rden, first_v, last_hs, done_cyc;
    int   h0 [NUM_CH];
    logic seen_done, prev_stall, prev_last;
    logic [63:0] prev_data, exp;
    base  = id * 256;
    total = v.k * (v.reuse + 1);
    for (int c = 0; c < NUM_CH; c++) h0[c] = hd[c];
    preload(v.exp_err ? 2 : v.k, base);

    @(negedge rd_clk);
    start = 1'b1; kernel_size = v.k[7:0]; reuse_cnt = v.reuse[7:0];
    @(negedge rd_clk);
    start = 1'b0; kernel_size = 8'd0; reuse_cnt = 8'd0;
    t0 = cyc;
    chk($sformatf("run%0d err_cfg", id), 64'(err_cfg), 64'(v.exp_err));

    if (v.exp_err) begin
      chk($sformatf("run%0d busy on bad cfg", id), 64'(busy), 64'd0);
      bad_rden = 0;
      for (int t = 0; t < 3; t++) begin
        @(negedge rd_clk);
        if (fifo_rd_en != '0 || busy) bad_rden++;
      end
      chk($sformatf("run%0d no pops on bad cfg", id), 64'(hd[0] - h0[0]), 64'd0);
      chk($sformatf("run%0d idle on bad cfg", id), 64'(bad_rden), 64'd0);
      flush();
      return;
    end

    chk($sformatf("run%0d busy in fill", id), 64'(busy), 64'd1);
    nb = 0; vc = 0; fillc = 0; bad_rden = 0;
    first_v = -1; last_hs = -1; done_cyc = -1;
    seen_done = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    for (int t = 0; t < 3000 && !seen_done; t++) begin
      stall[2] = v.stall2 && busy && !pe_valid && (fillc < 5);
      #1;
      if (stall[2]) begin
        fillc++;
        if (fifo_rd_en != '0) bad_rden++;
      end
      if (pe_valid) begin
        if (first_v < 0) first_v = cyc - t0;
        if (prev_stall) begin
          chk($sformatf("run%0d stall hold data", id), pe_data, prev_data);
          chk($sformatf("run%0d stall hold last", id), 64'(pe_last), 64'(prev_last));
        end
        pe_ready = (vc < 16) ? v.rpat[vc] : 1'b1;
        vc++;
        if (pe_ready) begin
          exp = '0;
          for (int c = 0; c < NUM_CH; c++) exp[c*DW +: DW] = DW'(base + c*16 + (nb % v.k));
          chk($sformatf("run%0d beat%0d data", id, nb), pe_data, exp);
          chk($sformatf("run%0d beat%0d last", id, nb), 64'(pe_last), 64'(nb == total - 1));
          nb++;
          last_hs = cyc - t0;
        end
        prev_stall = !pe_ready;
        prev_data  = pe_data;
        prev_last  = pe_last;
      end
      if (done) begin
        seen_done = 1'b1;
        done_cyc  = cyc - t0;
      end else begin
        @(negedge rd_clk);
      end
    end
    stall    = '0;
    pe_ready = 1'b1;
    chk($sformatf("run%0d done within budget", id), 64'(seen_done), 64'd1);
    chk($sformatf("run%0d beat count", id), 64'(nb), 64'(total));
    chk($sformatf("run%0d done after last beat", id), 64'(done_cyc), 64'(last_hs + 1));
    for (int c = 0; c < NUM_CH; c++)
      chk($sformatf("run%0d pops ch%0d", id, c), 64'(hd[c] - h0[c]), 64'(v.k));
    if (v.stall2) begin
      chk($sformatf("run%0d stall cycles seen", id), 64'(fillc), 64'd5);
      chk($sformatf("run%0d no pop while stalled", id), 64'(bad_rden), 64'd0);
    end else begin
      chk($sformatf("run%0d first valid cycle", id), 64'(first_v), 64'(v.k));
    end
    @(negedge rd_clk);
    chk($sformatf("run%0d done one cycle", id), 64'(done), 64'd0);
    chk($sformatf("run%0d busy after done", id), 64'(busy), 64'd0);
  endtask

  vec_t tv [8];
  vec_t hv;

  initial begin
    tv[0] = '{k: 3, reuse: 0, rpat: 16'hFFFF, stall2: 1'b0, exp_err: 1'b0};
    tv[1] = '{k: 2, reuse: 2, rpat: 16'hFFFF, stall2: 1'b0, exp_err: 1'b0};
    tv[2] = '{k: 3, reuse: 0, rpat: 16'hFFFF, stall2: 1'b1, exp_err: 1'b0};
    tv[3] = '{k: 4, reuse: 1, rpat: 16'hFFF9, stall2: 1'b0, exp_err: 1'b0};
    tv[4] = '{k: 0, reuse: 0, rpat: 16'hFFFF, stall2: 1'b0, exp_err: 1'b1};
    tv[5] = '{k: 9, reuse: 0, rpat: 16'hFFFF, stall2: 1'b0, exp_err: 1'b1};
    tv[6] = '{k: 8, reuse: 0, rpat: 16'hFFFF, stall2: 1'b0, exp_err: 1'b0};
    tv[7] = '{k: 1, reuse: 3, rpat: 16'hFFFA, stall2: 1'b0, exp_err: 1'b0};

    #12;
    chk("reset outputs", {fifo_rd_en, pe_valid, pe_data, pe_last, busy, done, err_cfg} != '0 ? 64'd1 : 64'd0, 64'd0);
    @(negedge rd_clk);
    rstn = 1'b1;
    @(negedge rd_clk);

    for (int i = 0; i < 8; i++) run_case(tv[i], i);

    // Pass counter at its limit: 256 replays of a one-word window.
    hv = '{k: 1, reuse: 255, rpat: 16'hFFFF, stall2: 1'b0, exp_err: 1'b0};
    run_case(hv, 8);

    // Asynchronous reset in the middle of ISSUE, then a normal run.
    preload(4, 9 * 256);
    @(negedge rd_clk);
    start = 1'b1; kernel_size = 8'd4; reuse_cnt = 8'd3;
    @(negedge rd_clk);
    start = 1'b0;
    for (int t = 0; t < 50 && !pe_valid; t++) @(negedge rd_clk);
    chk("reset test reached issue", 64'(pe_valid), 64'd1);
    @(negedge rd_clk);
    @(negedge rd_clk);
    #2 rstn = 1'b0;
    #1;
    chk("async reset rd_en",  64'(fifo_rd_en), 64'd0);
    chk("async reset valid",  64'(pe_valid), 64'd0);
    chk("async reset data",   pe_data, 64'd0);
    chk("async reset last/busy/done/err", 64'({pe_last, busy, done, err_cfg}), 64'd0);
    flush();
    @(negedge rd_clk);
    rstn = 1'b1;
    @(negedge rd_clk);
    chk("idle after reset", 64'(busy), 64'd0);
    hv = '{k: 3, reuse: 1, rpat: 16'hFFFD, stall2: 1'b0, exp_err: 1'b0};
    run_case(hv, 10);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
